video_scan_gen: RTL and testbench
=================================

# video_scan_gen

Parametrised video scan generator producing pixel-clock enable, raster counters, sync/blank, and text-cell coordinates from a single fast system clock. It replaces the fixed 640x480, fixed 8x8-cell scan logic at the top level. It feeds text and graphics peripherals with pre-decoded cell column, glyph row and text row. It adds per-frame fine vertical scroll, configurable cell size, sync polarity and pixel divide ratio.

## Interface
- PIX_DIV, 4: system clocks per pixel (≥1).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- HS_POL, 0; VS_POL, 0: active sync level.
- HSZ, 10; VSZ, 10: counter widths; must hold H_TOTAL-1 / V_TOTAL-1.
- CELL_W, 8; CELL_H, 8: cell size, power of two, 2..16. CW=log2(CELL_W), CH=log2(CELL_H).
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  synchronous, active-high reset.
- i_fine_scroll  in  CH  glyph-row offset, sampled at frame start.
- o_pix_ce  out  1  one-i_clk pixel enable.
- o_hcount  out  HSZ  current pixel column.
- o_vcount  out  VSZ  current line.
- o_de  out  1  active-area flag.
- o_hsync, o_vsync  out  1  sync outputs at configured polarity.
- o_cell_col  out  CW  pixel within cell.
- o_text_col  out  HSZ-CW  cell column.
- o_glyph_row  out  CH  row within glyph.
- o_text_row  out  VSZ  text row.
- o_line_start, o_frame_start  out  1  one-i_clk strobes.

## Operation
- Divider counts 0..PIX_DIV-1 on every i_clk. o_pix_ce=1 when divider==PIX_DIV-1. PIX_DIV=1 gives o_pix_ce constantly 1.
- On o_pix_ce, the position advances: hcount wraps at H_TOTAL-1 to 0. On that wrap, vcount increments and wraps at V_TOTAL-1 to 0.
- All outputs are registered and describe the pixel at (o_hcount, o_vcount). They change only in the cycle following a pix_ce and hold otherwise.
- o_de = hcount<H_ACTIVE && vcount<V_ACTIVE.
- hsync is active for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. vsync is active for the analogous vertical range.
- Horizontally: o_cell_col = hcount[CW-1:0]; o_text_col = hcount>>CW. Both are valid only when o_de=1.
- Glyph/text row state machine:
  - On entering (0,0), latch scroll S=i_fine_scroll, set glyph_row=S and text_row=0.
  - At the end of each active line (hcount H_ACTIVE-1→H_ACTIVE, vcount<V_ACTIVE), glyph_row increments.
  - When glyph_row is at CELL_H-1, it wraps to 0 and text_row increments.
  - Both hold through vertical blank.
- i_fine_scroll changes mid-frame have no effect until the next (0,0).
- o_line_start pulses with the pix_ce that makes hcount=0. o_frame_start pulses with the pix_ce that makes hcount=0 and vcount=0.
- Boundary cases:
  - text_row does not saturate; it wraps modulo 2^VSZ.
  - Last visible line with scroll≠0 produces a partial cell.
  - Simultaneous end-of-line and end-of-frame: the frame reload wins over the increment.

## Timing
- Reset values:
  - Divider 0.
  - o_hcount=H_TOTAL-1, o_vcount=V_TOTAL-1 (pre-start position).
  - o_de=0; syncs inactive (~HS_POL/~VS_POL).
  - o_cell_col, o_text_col, o_glyph_row, o_text_row 0.
  - o_pix_ce, o_line_start, o_frame_start 0.
- First o_pix_ce occurs PIX_DIV cycles after reset release. The next cycle presents (0,0) with o_de=1 and o_frame_start=1.
- Latency from pix_ce to updated outputs is 1 i_clk.
- Reset asserted mid-frame returns all outputs to reset values on the next i_clk, with no partial sync pulse extension.

## Configuration
- SCAN_LINE_DOUBLE_EN defined:
  - Glyph row advances only on every second active line (odd vcount end), so each glyph row spans two scanlines.
  - Text rows span 2*CELL_H lines.
  - Scroll S is still in glyph-row units.
- SCAN_LINE_DOUBLE_EN undefined: glyph row advances on every active line, as described above.

## Test plan
- Reset release, PIX_DIV=4: o_pix_ce high on cycles 4, 8, 12…. o_frame_start at cycle 5 with o_hcount=0, o_vcount=0, o_de=1.
- One full frame, default timing: 800×525 pixels; o_de high for 307200 pixels. o_hsync low for hcount 656..751. o_vsync low for vcount 490..491. Exactly one o_frame_start and 525 o_line_start.
- i_fine_scroll=3, CELL_H=8: line 0 glyph_row=3, text_row=0. Line 5 glyph_row=0, text_row=1. Line 479 glyph_row=2, text_row=60.
- i_fine_scroll changed 0→5 at vcount 100: rows unchanged for the rest of the frame. Next frame line 0 glyph_row=5.
- Assert i_rst at (300,200) for 1 cycle: next cycle o_hcount=799, o_vcount=524, o_de=0, syncs inactive. Restart matches the first scenario.
- SCAN_LINE_DOUBLE_EN, scroll 0: lines 0–1 glyph_row 0, lines 14–15 glyph_row 7, line 16 text_row=1.

Source files
------------

// File: rtl/video_scan_gen_if.sv
// Signal bundle between the video scan generator and its text/graphics consumers.
interface video_scan_gen_if #(
  parameter int HSZ = 10,
  parameter int VSZ = 10,
  parameter int CW  = 3,
  parameter int CH  = 3
);
  logic [CH-1:0]     i_fine_scroll;
  logic              o_pix_ce;
  logic [HSZ-1:0]    o_hcount;
  logic [VSZ-1:0]    o_vcount;
  logic              o_de;
  logic              o_hsync;
  logic              o_vsync;
  logic [CW-1:0]     o_cell_col;
  logic [HSZ-CW-1:0] o_text_col;
  logic [CH-1:0]     o_glyph_row;
  logic [VSZ-1:0]    o_text_row;
  logic              o_line_start;
  logic              o_frame_start;

  modport master (
    input  i_fine_scroll,
    output o_pix_ce, o_hcount, o_vcount, o_de, o_hsync, o_vsync,
           o_cell_col, o_text_col, o_glyph_row, o_text_row,
           o_line_start, o_frame_start
  );

  modport slave (
    output i_fine_scroll,
    input  o_pix_ce, o_hcount, o_vcount, o_de, o_hsync, o_vsync,
           o_cell_col, o_text_col, o_glyph_row, o_text_row,
           o_line_start, o_frame_start
  );
endinterface

// File: rtl/video_scan_gen.sv
// Parametrised raster scan generator with pixel enable, sync/blank and text-cell coordinates.
// Optional macro SCAN_LINE_DOUBLE_EN: each glyph row spans two scanlines.
module video_scan_gen #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int HSZ      = 10,
  parameter int VSZ      = 10,
  parameter int CELL_W   = 8,
  parameter int CELL_H   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  video_scan_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = $clog2(CELL_W);
  localparam int CH      = $clog2(CELL_H);
  localparam int DIVW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(PIX_DIV - 1);
  localparam logic [HSZ-1:0]  H_LAST     = HSZ'(H_TOTAL - 1);
  localparam logic [HSZ-1:0]  H_ACT      = HSZ'(H_ACTIVE);
  localparam logic [HSZ-1:0]  H_ACT_LAST = HSZ'(H_ACTIVE - 1);
  localparam logic [HSZ-1:0]  HS_FIRST   = HSZ'(H_ACTIVE + H_FP);
  localparam logic [HSZ-1:0]  HS_LAST    = HSZ'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VSZ-1:0]  V_LAST     = VSZ'(V_TOTAL - 1);
  localparam logic [VSZ-1:0]  V_ACT      = VSZ'(V_ACTIVE);
  localparam logic [VSZ-1:0]  VS_FIRST   = VSZ'(V_ACTIVE + V_FP);
  localparam logic [VSZ-1:0]  VS_LAST    = VSZ'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CH-1:0]   GLYPH_LAST = CH'(CELL_H - 1);
  localparam logic            HS_ON      = (HS_POL != 0);
  localparam logic            VS_ON      = (VS_POL != 0);

  logic [DIVW-1:0]   div_q, div_d;
  logic              pix_ce_q, pix_ce_d;
  logic [HSZ-1:0]    h_q, h_d;
  logic [VSZ-1:0]    v_q, v_d;
  logic              de_q, de_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic [CW-1:0]     cell_col_q, cell_col_d;
  logic [HSZ-CW-1:0] text_col_q, text_col_d;
  logic [CH-1:0]     glyph_q, glyph_d;
  logic [VSZ-1:0]    text_row_q, text_row_d;
  logic              line_q, line_d;
  logic              frame_q, frame_d;

  logic           h_wrap, frame_wrap, active_eol, row_step;
  logic [HSZ-1:0] h_next;
  logic [VSZ-1:0] v_next;

  // Line doubling advances the glyph row only after odd scanlines.
`ifdef SCAN_LINE_DOUBLE_EN
  assign row_step = v_q[0];
`else
  assign row_step = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_ce_d   = (div_q == DIV_LAST);
    h_wrap     = (h_q == H_LAST);
    h_next     = h_wrap ? '0 : h_q + 1'b1;
    v_next     = h_wrap ? ((v_q == V_LAST) ? '0 : v_q + 1'b1) : v_q;
    frame_wrap = h_wrap && (v_q == V_LAST);
    active_eol = (h_q == H_ACT_LAST) && (v_q < V_ACT);

    h_d        = h_q;
    v_d        = v_q;
    de_d       = de_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    cell_col_d = cell_col_q;
    text_col_d = text_col_q;
    glyph_d    = glyph_q;
    text_row_d = text_row_q;
    line_d     = 1'b0;
    frame_d    = 1'b0;

    if (pix_ce_q) begin
      h_d        = h_next;
      v_d        = v_next;
      de_d       = (h_next < H_ACT) && (v_next < V_ACT);
      hs_d       = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? HS_ON : ~HS_ON;
      vs_d       = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? VS_ON : ~VS_ON;
      cell_col_d = h_next[CW-1:0];
      text_col_d = h_next[HSZ-1:CW];
      line_d     = h_wrap;
      frame_d    = frame_wrap;

      // Frame reload takes priority over the end-of-line row advance.
      if (frame_wrap) begin
        glyph_d    = bus.i_fine_scroll;
        text_row_d = '0;
      end else if (active_eol && row_step) begin
        if (glyph_q == GLYPH_LAST) begin
          glyph_d    = '0;
          text_row_d = text_row_q + 1'b1;
        end else begin
          glyph_d    = glyph_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so all update from the same pre-edge values.
    if (i_rst) begin
      div_q      <= '0;
      pix_ce_q   <= 1'b0;
      h_q        <= H_LAST;
      v_q        <= V_LAST;
      de_q       <= 1'b0;
      hs_q       <= ~HS_ON;
      vs_q       <= ~VS_ON;
      cell_col_q <= '0;
      text_col_q <= '0;
      glyph_q    <= '0;
      text_row_q <= '0;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      pix_ce_q   <= pix_ce_d;
      h_q        <= h_d;
      v_q        <= v_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      cell_col_q <= cell_col_d;
      text_col_q <= text_col_d;
      glyph_q    <= glyph_d;
      text_row_q <= text_row_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.o_pix_ce      = pix_ce_q;
  assign bus.o_hcount      = h_q;
  assign bus.o_vcount      = v_q;
  assign bus.o_de          = de_q;
  assign bus.o_hsync       = hs_q;
  assign bus.o_vsync       = vs_q;
  assign bus.o_cell_col    = cell_col_q;
  assign bus.o_text_col    = text_col_q;
  assign bus.o_glyph_row   = glyph_q;
  assign bus.o_text_row    = text_row_q;
  assign bus.o_line_start  = line_q;
  assign bus.o_frame_start = frame_q;

endmodule

// File: tb/tb_video_scan_gen.sv
// Self-checking bench for video_scan_gen: a pixel-index model of the raster checked every cycle.
module tb_video_scan_gen;

  localparam int PIX_DIV  = 4;
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 20;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int HS_POL   = 0;
  localparam int VS_POL   = 1;
  localparam int HSZ      = 5;
  localparam int VSZ      = 5;
  localparam int CELL_W   = 4;
  localparam int CELL_H   = 8;
  localparam int CW       = 2;
  localparam int CH       = 3;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int N_CYCLES = 32000;

`ifdef SCAN_LINE_DOUBLE_EN
  localparam int LD = 2;
  localparam int LIT5_G = 5, LIT5_T = 0, LIT19_G = 4, LIT19_T = 1;
`else
  localparam int LD = 1;
  localparam int LIT5_G = 0, LIT5_T = 1, LIT19_G = 6, LIT19_T = 2;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  video_scan_gen_if #(.HSZ(HSZ), .VSZ(VSZ), .CW(CW), .CH(CH)) vif ();

  video_scan_gen #(
    .PIX_DIV(PIX_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HSZ(HSZ), .VSZ(VSZ),
    .CELL_W(CELL_W), .CELL_H(CELL_H)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (vif.master)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc        = 0;
  int cur_scroll = 3;
  int s_latched  = 0;
  int frame_no   = 0;
  int m_h        = 0;
  int m_v        = 0;
  bit m_fresh    = 1'b0;
  int de_cnt     = 0;
  int ls_cnt     = 0;
  int fs_cnt     = 0;
  bit full_frame = 1'b0;
  bit rst_drv    = 1'b1;
  bit scroll5_done = 1'b0;
  bit rst_done   = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", name, actual, expected, cyc, $time);
  endtask

  // cyc counts clock edges since the last edge that sampled reset.
  task automatic compare_cycle();
    int p;
    int rows;
    bit de_e;
    bit hs_act;
    bit vs_act;

    check("pix_ce", vif.o_pix_ce, (cyc > 0 && cyc % PIX_DIV == 0) ? 1 : 0);
    if (cyc == PIX_DIV) check("first_pix_ce", vif.o_pix_ce, 1);
    m_fresh = 1'b0;

    if (cyc <= PIX_DIV) begin
      check("rst_hcount", vif.o_hcount, H_TOTAL - 1);
      check("rst_vcount", vif.o_vcount, V_TOTAL - 1);
      check("rst_de", vif.o_de, 0);
      check("rst_hsync", vif.o_hsync, 1 - HS_POL);
      check("rst_vsync", vif.o_vsync, 1 - VS_POL);
      check("rst_cell_col", vif.o_cell_col, 0);
      check("rst_text_col", vif.o_text_col, 0);
      check("rst_glyph_row", vif.o_glyph_row, 0);
      check("rst_text_row", vif.o_text_row, 0);
      check("rst_line_start", vif.o_line_start, 0);
      check("rst_frame_start", vif.o_frame_start, 0);
    end else begin
      p       = (cyc - 1) / PIX_DIV - 1;
      m_fresh = ((cyc - 1) % PIX_DIV == 0);
      m_h     = p % H_TOTAL;
      m_v     = (p / H_TOTAL) % V_TOTAL;

      if (m_fresh && m_h == 0 && m_v == 0) begin
        s_latched = cur_scroll;
        if (full_frame) begin
          check("frame_de_pixels", de_cnt, 320);
          check("frame_line_starts", ls_cnt, 26);
          check("frame_frame_starts", fs_cnt, 1);
        end
        de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
        full_frame = 1'b1;
        frame_no++;
      end

      de_e   = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
      hs_act = (m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC);
      vs_act = (m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC);

      check("hcount", vif.o_hcount, m_h);
      check("vcount", vif.o_vcount, m_v);
      check("de", vif.o_de, de_e ? 1 : 0);
      check("hsync", vif.o_hsync, hs_act ? HS_POL : 1 - HS_POL);
      check("vsync", vif.o_vsync, vs_act ? VS_POL : 1 - VS_POL);
      check("line_start", vif.o_line_start, (m_fresh && m_h == 0) ? 1 : 0);
      check("frame_start", vif.o_frame_start, (m_fresh && m_h == 0 && m_v == 0) ? 1 : 0);

      if (m_fresh) de_cnt += int'(vif.o_de);
      ls_cnt += int'(vif.o_line_start);
      fs_cnt += int'(vif.o_frame_start);

      // Rows count completed active lines (halved when doubling) on top of the latched scroll.
      if (m_v >= V_ACTIVE)      rows = s_latched + V_ACTIVE / LD;
      else if (m_h >= H_ACTIVE) rows = s_latched + (m_v + 1) / LD;
      else                      rows = s_latched + m_v / LD;
      check("glyph_row", vif.o_glyph_row, rows % CELL_H);
      check("text_row", vif.o_text_row, (rows / CELL_H) % (1 << VSZ));

      if (de_e) begin
        check("cell_col", vif.o_cell_col, m_h % CELL_W);
        check("text_col", vif.o_text_col, m_h / CELL_W);
      end

      if (cyc == PIX_DIV + 1) begin
        check("first_hcount", vif.o_hcount, 0);
        check("first_vcount", vif.o_vcount, 0);
        check("first_de", vif.o_de, 1);
        check("first_frame_start", vif.o_frame_start, 1);
      end
      if (m_fresh && m_h == 0 && s_latched == 3) begin
        if (m_v == 0) check("lit_l0_glyph", vif.o_glyph_row, 3);
        if (m_v == 5) begin
          check("lit_l5_glyph", vif.o_glyph_row, LIT5_G);
          check("lit_l5_text", vif.o_text_row, LIT5_T);
        end
        if (m_v == 19) begin
          check("lit_l19_glyph", vif.o_glyph_row, LIT19_G);
          check("lit_l19_text", vif.o_text_row, LIT19_T);
        end
      end
      if (m_fresh && m_v == 1) begin
        if (m_h == 17) check("lit_hsync_idle", vif.o_hsync, 1);
        if (m_h == 18) check("lit_hsync_on", vif.o_hsync, 0);
        if (m_h == 20) check("lit_hsync_last", vif.o_hsync, 0);
      end
      if (m_fresh && m_h == 0 && m_v == 0 && frame_no == 3 && scroll5_done)
        check("scroll5_next_frame", vif.o_glyph_row, 5);
    end
  endtask

  initial begin
    vif.i_fine_scroll = CH'(cur_scroll);
    i_rst = 1'b1;
    for (int k = 0; k < N_CYCLES; k++) begin
      @(negedge i_clk);
      if (rst_drv) begin
        cyc = 0;
        full_frame = 1'b0;
      end else begin
        cyc++;
      end
      compare_cycle();

      rst_drv = (k < 3);
      if (frame_no == 2 && m_fresh && m_h == 0 && m_v == 10 && !scroll5_done) begin
        cur_scroll   = 5;
        scroll5_done = 1'b1;
      end
      if (frame_no == 4 && m_fresh && m_h == 10 && m_v == 12 && !rst_done) begin
        rst_drv  = 1'b1;
        rst_done = 1'b1;
      end
      if (k > 12000) begin
        if ($urandom_range(0, 4999) == 0) rst_drv = 1'b1;
        if ($urandom_range(0, 199) == 0) cur_scroll = int'($urandom_range(0, CELL_H - 1));
      end
      i_rst = rst_drv;
      vif.i_fine_scroll = CH'(cur_scroll);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
